// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data-bus transactions, stall, load extension.
// Optional LL/SC support is compiled in with `define MEM_LSU_LLSC_EN.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        mem_aluop,
  input  logic [31:0]       mem_mem_addr,
  input  logic [31:0]       mem_reg2_data,
  input  logic [31:0]       mem_alu_res,
  input  logic              exc_pending,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [31:0]       wb_data,
  output logic              stallreq,
  output logic              exc_adel,
  output logic              exc_ades
);

  localparam logic [7:0] ALU_LB_OP  = 8'hE0;
  localparam logic [7:0] ALU_LBU_OP = 8'hE4;
  localparam logic [7:0] ALU_LH_OP  = 8'hE1;
  localparam logic [7:0] ALU_LHU_OP = 8'hE5;
  localparam logic [7:0] ALU_LW_OP  = 8'hE3;
  localparam logic [7:0] ALU_SB_OP  = 8'hE8;
  localparam logic [7:0] ALU_SH_OP  = 8'hE9;
  localparam logic [7:0] ALU_SW_OP  = 8'hEB;
`ifdef MEM_LSU_LLSC_EN
  localparam logic [7:0] ALU_LL_OP  = 8'hF0;
  localparam logic [7:0] ALU_SC_OP  = 8'hF8;
`endif

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        is_load;
  logic        is_store;
  logic        sext;
  logic [1:0]  size;
  logic        misalign;
  logic        mem_op;
  logic        access;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] load_val;
  logic [1:0]  a;

`ifdef MEM_LSU_LLSC_EN
  logic is_ll;
  logic is_sc;
  logic llbit_q, llbit_d;
`endif

  assign a = mem_mem_addr[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_W;
`ifdef MEM_LSU_LLSC_EN
    is_ll    = 1'b0;
    is_sc    = 1'b0;
`endif
    case (mem_aluop)
      ALU_LB_OP:  begin is_load = 1'b1; size = SZ_B; sext = 1'b1; end
      ALU_LBU_OP: begin is_load = 1'b1; size = SZ_B; end
      ALU_LH_OP:  begin is_load = 1'b1; size = SZ_H; sext = 1'b1; end
      ALU_LHU_OP: begin is_load = 1'b1; size = SZ_H; end
      ALU_LW_OP:  is_load = 1'b1;
      ALU_SB_OP:  begin is_store = 1'b1; size = SZ_B; end
      ALU_SH_OP:  begin is_store = 1'b1; size = SZ_H; end
      ALU_SW_OP:  is_store = 1'b1;
`ifdef MEM_LSU_LLSC_EN
      ALU_LL_OP:  begin is_load = 1'b1; is_ll = 1'b1; end
      ALU_SC_OP:  begin is_store = 1'b1; is_sc = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign mem_op   = is_load | is_store;
  assign misalign = ((size == SZ_H) & a[0]) |
                    ((size == SZ_W) & (a != 2'b00));
  assign exc_adel = is_load & misalign;
  assign exc_ades = is_store & misalign;

`ifdef MEM_LSU_LLSC_EN
  // A failed SC never reaches the bus.
  assign access = mem_op & ~misalign & ~exc_pending & ~flush &
                  ~(is_sc & ~llbit_q);
`else
  assign access = mem_op & ~misalign & ~exc_pending & ~flush;
`endif

  // Big-endian lanes: byte address 0 lives in bits 31:24.
  always_comb begin
    sel   = 4'b1111;
    wdata = mem_reg2_data;
    case (size)
      SZ_B: begin
        sel   = 4'b1000 >> a;
        wdata = {4{mem_reg2_data[7:0]}};
      end
      SZ_H: begin
        sel   = a[1] ? 4'b0011 : 4'b1100;
        wdata = {2{mem_reg2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (a)
      2'd0:    ld_b = rdata_q[31:24];
      2'd1:    ld_b = rdata_q[23:16];
      2'd2:    ld_b = rdata_q[15:8];
      default: ld_b = rdata_q[7:0];
    endcase
    ld_h = a[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (size)
      SZ_B:    load_val = sext ? {{24{ld_b[7]}}, ld_b} : {24'b0, ld_b};
      SZ_H:    load_val = sext ? {{16{ld_h[15]}}, ld_h} : {16'b0, ld_h};
      default: load_val = rdata_q;
    endcase
  end

  always_comb begin
    wb_data = mem_alu_res;
    if (is_load) wb_data = load_val;
`ifdef MEM_LSU_LLSC_EN
    // llbit is already cleared in DONE, so success is implied by the state.
    if (is_sc) wb_data = {31'b0, (state_q == DONE) | llbit_q};
`endif
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    stallreq    = 1'b0;
`ifdef MEM_LSU_LLSC_EN
    llbit_d     = llbit_q;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          stallreq    = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
          bus_sel_d   = sel;
          bus_wdata_d = wdata;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        stallreq = 1'b1;
        if (flush) begin
          if (bus_ack) begin
            bus_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (bus_ack) begin
          rdata_d   = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = DONE;
`ifdef MEM_LSU_LLSC_EN
          if (is_ll) llbit_d = 1'b1;
          if (is_sc) llbit_d = 1'b0;
`endif
        end
      end
      DONE: state_d = IDLE;
      DRAIN: begin
        // The bus cannot retract a request, so wait out the orphan ack.
        stallreq = access;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_LSU_LLSC_EN
    if (flush) llbit_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0;
      bus_wdata_q <= '0;
      rdata_q     <= 32'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MEM_LSU_LLSC_EN
  always_ff @(posedge clk) begin
    if (rst) llbit_q <= 1'b0;
    else     llbit_q <= llbit_d;
  end
`endif

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: bus scoreboard plus wb_data scoreboard.
// Define MEM_LSU_LLSC_EN for both RTL and bench to exercise LL/SC.
module tb_mem_lsu;

  localparam logic [7:0] OP_NOP = 8'h21;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2_data;
  logic [31:0] mem_alu_res;
  logic        exc_pending;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] wb_data;
  logic        stallreq;
  logic        exc_adel;
  logic        exc_ades;

  mem_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2_data(mem_reg2_data),
    .mem_alu_res  (mem_alu_res),
    .exc_pending  (exc_pending),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_sel      (bus_sel),
    .bus_wdata    (bus_wdata),
    .wb_data      (wb_data),
    .stallreq     (stallreq),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wd;
    int          dly;
    logic [31:0] rdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] wb_q[$];
  bus_t        cur;
  int          req_cnt;
  int          n_assert;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wd,
                         input logic chk, input int dly,
                         input logic [31:0] rd);
    bus_t b;
    b.we = we; b.addr = addr; b.sel = sel; b.wdata = wd;
    b.chk_wd = chk; b.dly = dly; b.rdata = rd;
    bus_q.push_back(b);
  endtask

  // Bus slave: checks each new request against the queue, acks after dly cycles.
  always @(negedge clk) begin
    if (!bus_req) begin
      req_cnt = 0;
      bus_ack = 1'b0;
    end else begin
      req_cnt++;
      if (req_cnt == 1) begin
        check("req expected", 32'(bus_q.size() != 0), 32'd1);
        if (bus_q.size() != 0) begin
          cur = bus_q.pop_front();
          check("bus_we", 32'(bus_we), 32'(cur.we));
          check("bus_addr", bus_addr, cur.addr);
          check("bus_sel", 32'(bus_sel), 32'(cur.sel));
          if (cur.chk_wd) check("bus_wdata", bus_wdata, cur.wdata);
        end else begin
          cur.dly = 1;
          cur.rdata = 32'h0;
        end
      end
      bus_ack = (req_cnt == cur.dly);
      bus_rdata = cur.rdata;
    end
  end

  task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [31:0] alu);
    mem_aluop = op;
    mem_mem_addr = addr;
    mem_reg2_data = rt;
    mem_alu_res = alu;
  endtask

  task automatic nop();
    drive(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  // Called #1 after a posedge; returns #1 after the posedge ending the op.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] alu, input int exp_stall,
                        input logic [31:0] exp_wb);
    int n;
    bit done;
    logic [31:0] e;
    drive(op, addr, rt, alu);
    wb_q.push_back(exp_wb);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (stallreq) n++;
      else done = 1'b1;
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
    e = wb_q.pop_front();
    check({tag, " wb_data"}, wb_data, e);
    @(posedge clk); #1;
    nop();
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    req_cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    rst = 1'b1;
    flush = 1'b0;
    exc_pending = 1'b0;
    nop();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("por bus_req", 32'(bus_req), 32'd0);
    check("por bus_we", 32'(bus_we), 32'd0);
    check("por bus_addr", bus_addr, 32'h0);
    check("por bus_sel", 32'(bus_sel), 32'd0);
    check("por bus_wdata", bus_wdata, 32'h0);
    check("por stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_bus(1'b0, 32'h100, 4'b0001, 32'h0, 1'b0, 1, 32'h112233F0);
    run_op("lb", OP_LB, 32'h103, 32'h0, 32'h0, 2, 32'hFFFFFFF0);
    exp_bus(1'b0, 32'h100, 4'b0001, 32'h0, 1'b0, 1, 32'h112233F0);
    run_op("lbu", OP_LBU, 32'h103, 32'h0, 32'h0, 2, 32'h000000F0);

    exp_bus(1'b1, 32'h200, 4'b0011, 32'hABCDABCD, 1'b1, 3, 32'h0);
    run_op("sh", OP_SH, 32'h202, 32'h0000ABCD, 32'h12345678, 4, 32'h12345678);

    exp_bus(1'b0, 32'h100, 4'b0011, 32'h0, 1'b0, 1, 32'h11228001);
    run_op("lh", OP_LH, 32'h102, 32'h0, 32'h0, 2, 32'hFFFF8001);
    exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 1'b0, 1, 32'h80011122);
    run_op("lhu", OP_LHU, 32'h100, 32'h0, 32'h0, 2, 32'h00008001);
    exp_bus(1'b0, 32'h104, 4'b1111, 32'h0, 1'b0, 2, 32'hDEADBEEF);
    run_op("lw", OP_LW, 32'h104, 32'h0, 32'h0, 3, 32'hDEADBEEF);
    exp_bus(1'b1, 32'h300, 4'b0100, 32'hA5A5A5A5, 1'b1, 1, 32'h0);
    run_op("sb", OP_SB, 32'h301, 32'h000000A5, 32'h301, 2, 32'h301);
    exp_bus(1'b1, 32'h308, 4'b1111, 32'hCAFEF00D, 1'b1, 2, 32'h0);
    run_op("sw", OP_SW, 32'h308, 32'hCAFEF00D, 32'h308, 3, 32'h308);
    run_op("alu op", OP_NOP, 32'h0, 32'h0, 32'h000055AA, 0, 32'h000055AA);

    drive(OP_LW, 32'h301, 32'h0, 32'h0);
    @(negedge clk);
    check("lw mis adel", 32'(exc_adel), 32'd1);
    check("lw mis ades", 32'(exc_ades), 32'd0);
    check("lw mis stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    drive(OP_SH, 32'h205, 32'h0, 32'h0);
    @(negedge clk);
    check("sh mis ades", 32'(exc_ades), 32'd1);
    check("sh mis adel", 32'(exc_adel), 32'd0);
    check("sh mis stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    drive(OP_LW, 32'h104, 32'h0, 32'h0);
    exc_pending = 1'b1;
    @(negedge clk);
    check("exc_pending stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    exc_pending = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("idle flush stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    nop();
    repeat (2) @(negedge clk);
    check("no req after mis", 32'(bus_req), 32'd0);

    // Flush while BUSY, then a new load queued behind the orphan ack.
    @(posedge clk); #1;
    exp_bus(1'b0, 32'h500, 4'b1111, 32'h0, 1'b0, 3, 32'h99999999);
    exp_bus(1'b0, 32'h600, 4'b1111, 32'h0, 1'b0, 1, 32'h80706050);
    drive(OP_LW, 32'h500, 32'h0, 32'h0);
    @(negedge clk);
    check("fl idle stall", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("fl busy req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(OP_LW, 32'h600, 32'h0, 32'h0);
    wb_q.push_back(32'h80706050);
    @(negedge clk);
    check("drain1 req", 32'(bus_req), 32'd1);
    check("drain1 stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    check("drain2 req", 32'(bus_req), 32'd1);
    check("drain2 stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    check("drain done req", 32'(bus_req), 32'd0);
    check("new idle stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    check("new busy req", 32'(bus_req), 32'd1);
    check("new busy stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    check("new done stall", 32'(stallreq), 32'd0);
    check("new done wb", wb_data, wb_q.pop_front());
    @(posedge clk); #1;
    nop();

`ifdef MEM_LSU_LLSC_EN
    exp_bus(1'b0, 32'h400, 4'b1111, 32'h0, 1'b0, 1, 32'h13572468);
    run_op("ll", OP_LL, 32'h400, 32'h0, 32'h400, 2, 32'h13572468);
    exp_bus(1'b1, 32'h400, 4'b1111, 32'hFEEDFACE, 1'b1, 1, 32'h0);
    run_op("sc ok", OP_SC, 32'h400, 32'hFEEDFACE, 32'h400, 2, 32'h1);
    exp_bus(1'b0, 32'h400, 4'b1111, 32'h0, 1'b0, 1, 32'h2468ACE0);
    run_op("ll2", OP_LL, 32'h400, 32'h0, 32'h400, 2, 32'h2468ACE0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("sc fail", OP_SC, 32'h400, 32'hFEEDFACE, 32'h400, 0, 32'h0);
`else
    run_op("ll nonmem", OP_LL, 32'h400, 32'h0, 32'hAAAA0001, 0, 32'hAAAA0001);
    run_op("sc nonmem", OP_SC, 32'h400, 32'h1, 32'hAAAA0002, 0, 32'hAAAA0002);
`endif

    // Reset in the middle of a transaction that is never acked.
    exp_bus(1'b1, 32'h700, 4'b1111, 32'h11111111, 1'b1, 1000, 32'h0);
    drive(OP_SW, 32'h700, 32'h11111111, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst pre req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    nop();
    @(posedge clk);
    @(negedge clk);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst stallreq", 32'(stallreq), 32'd0);
    check("rst bus_we", 32'(bus_we), 32'd0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst bus_sel", 32'(bus_sel), 32'd0);
    check("rst bus_wdata", bus_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (4) @(negedge clk);
    check("bus queue empty", 32'(bus_q.size()), 32'd0);
    check("wb queue empty", 32'(wb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
